// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter: round-robin share of one register-file
// read/write port pair between two requesters, one op in flight.
// Ports: clk, rst (async, active-high); req_* valid/ready request
// channel per port; rsp_valid/rsp_err/rsp_rdata response pulse;
// rf_re/rf_raddr/rf_rdata and rf_we/rf_waddr/rf_wdata to the
// register file; busy = FSM not idle.
// Optional: define RF_ARB_PERF_EN to add clr_cnt and per-port
// saturating grant counters grant_cnt0/grant_cnt1.
module regfile_access_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rf_re,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy
`ifdef RF_ARB_PERF_EN
  ,
  input  logic              clr_cnt,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic r_rr_last;
  logic r_owner;
  logic r_write;

  logic              w_win;
  logic              w_acc;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_illegal;
  logic              w_rsp_owner;

  // Port 1 wins when it is the only requester, or when both
  // request and port 1 was not the last one granted.
  assign w_win = req_valid[1] & (~req_valid[0] | ~r_rr_last);

  assign req_ready = (r_state == S_IDLE && |req_valid)
                   ? (w_win ? 2'b10 : 2'b01) : 2'b00;

  assign w_acc = |(req_valid & req_ready);

  assign w_sel_write = w_win ? req_write[1] : req_write[0];
  assign w_sel_addr  = w_win ? req_addr1 : req_addr0;
  assign w_sel_wdata = w_win ? req_wdata1 : req_wdata0;

  assign w_illegal = (32'(w_sel_addr) >= 32'(DEPTH))
                   | (w_sel_write & (w_sel_addr == '0));

  // An error response leaves IDLE before the owner is latched.
  assign w_rsp_owner = (r_state == S_IDLE) ? w_win : r_owner;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) w_nxt = w_illegal ? S_RESP : S_ISSUE;
      end
      S_ISSUE: w_nxt = r_write ? S_RESP : S_WAIT;
      S_WAIT:  w_nxt = S_RESP;
      S_RESP:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rr_last <= 1'b1;
      r_owner   <= 1'b0;
      r_write   <= 1'b0;
      busy      <= 1'b0;
      rf_re     <= 1'b0;
      rf_raddr  <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      rsp_valid <= 2'b00;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      r_state <= w_nxt;
      busy    <= (w_nxt != S_IDLE);
      if (w_acc) begin
        r_owner   <= w_win;
        r_rr_last <= w_win;
        r_write   <= w_sel_write;
      end
      rf_re    <= 1'b0;
      rf_raddr <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      if (w_acc && !w_illegal) begin
        if (w_sel_write) begin
          rf_we    <= 1'b1;
          rf_waddr <= w_sel_addr;
          rf_wdata <= w_sel_wdata;
        end else begin
          rf_re    <= 1'b1;
          rf_raddr <= w_sel_addr;
        end
      end
      rsp_valid <= 2'b00;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      if (w_nxt == S_RESP) begin
        rsp_valid <= w_rsp_owner ? 2'b10 : 2'b01;
        // Only an illegal op jumps from IDLE straight to RESP.
        rsp_err   <= (r_state == S_IDLE);
        if (r_state == S_WAIT) rsp_rdata <= rf_rdata;
      end
    end
  end

`ifdef RF_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (clr_cnt) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (w_acc) begin
      if (!w_win && grant_cnt0 != 16'hFFFF)
        grant_cnt0 <= grant_cnt0 + 16'd1;
      if (w_win && grant_cnt1 != 16'hFFFF)
        grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// tb_regfile_access_arbiter: directed checks of the two-port
// register-file arbiter against a small registered-read RF model.
module tb_regfile_access_arbiter;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_write;
  logic [AW-1:0] req_addr0;
  logic [AW-1:0] req_addr1;
  logic [DW-1:0] req_wdata0;
  logic [DW-1:0] req_wdata1;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          rf_re;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          busy;
`ifdef RF_ARB_PERF_EN
  logic          clr_cnt;
  logic [15:0]   grant_cnt0;
  logic [15:0]   grant_cnt1;
`endif

  int n_chk = 0;
  int n_err = 0;

  regfile_access_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(3)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy)
`ifdef RF_ARB_PERF_EN
    ,
    .clr_cnt(clr_cnt),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [4] = '{8'h00, 8'h11, 8'h22, 8'h33};

  always @(posedge clk) begin
    if (rf_re) rf_rdata <= mem[rf_raddr];
    if (rf_we && rf_waddr != '0) mem[rf_waddr] <= rf_wdata;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic g;
    rst = 1'b1;
    req_valid = '0; req_write = '0;
    req_addr0 = '0; req_addr1 = '0;
    req_wdata0 = '0; req_wdata1 = '0;
    rf_rdata = '0;
`ifdef RF_ARB_PERF_EN
    clr_cnt = 1'b0;
`endif
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_re", rf_re, 0);
    chk("rst_ready", req_ready, 0);
    rst = 1'b0;
    tick;

    // contention: both ports read, grants must alternate 0,1,0,1
    req_valid = 2'b11; req_write = 2'b00;
    req_addr0 = 2; req_addr1 = 1;
    for (int t = 0; t < 4; t++) begin
      g = t[0];
      #1;
      chk("cont_ready", req_ready, g ? 2 : 1);
      chk("cont_not11", req_ready == 2'b11, 0);
      tick;
      chk("cont_re", rf_re, 1);
      chk("cont_raddr", rf_raddr, g ? 1 : 2);
      chk("cont_busy_ready", req_ready, 0);
      chk("cont_busy", busy, 1);
      tick;
      chk("cont_wait_rsp", rsp_valid, 0);
      tick;
      chk("cont_rsp", rsp_valid, g ? 2 : 1);
      chk("cont_rdata", rsp_rdata, g ? 8'h11 : 8'h22);
      chk("cont_err", rsp_err, 0);
      tick;
    end
    req_valid = 2'b00;

    // port 0 write addr 1 = A5, then read it back
    req_valid = 2'b01; req_write = 2'b01;
    req_addr0 = 1; req_wdata0 = 8'hA5;
    #1;
    chk("wr_ready", req_ready, 1);
    tick;
    req_valid = 2'b00;
    chk("wr_we", rf_we, 1);
    chk("wr_waddr", rf_waddr, 1);
    chk("wr_wdata", rf_wdata, 8'hA5);
    chk("wr_no_rsp", rsp_valid, 0);
    tick;
    chk("wr_rsp", rsp_valid, 1);
    chk("wr_err", rsp_err, 0);
    chk("wr_rdata0", rsp_rdata, 0);
    chk("wr_we_off", rf_we, 0);
    tick;
    chk("wr_idle", busy, 0);
    req_valid = 2'b01; req_write = 2'b00;
    #1;
    chk("rd_ready", req_ready, 1);
    tick;
    req_valid = 2'b00;
    chk("rd_re", rf_re, 1);
    chk("rd_raddr", rf_raddr, 1);
    tick;
    chk("rd_wait_rsp", rsp_valid, 0);
    tick;
    chk("rd_rsp", rsp_valid, 1);
    chk("rd_rdata", rsp_rdata, 8'hA5);
    chk("rd_err", rsp_err, 0);
    tick;

    // port 1 write to addr 0 is illegal
    req_valid = 2'b10; req_write = 2'b10;
    req_addr1 = 0; req_wdata1 = 8'h77;
    #1;
    chk("w0_ready", req_ready, 2);
    tick;
    req_valid = 2'b00;
    chk("w0_rsp", rsp_valid, 2);
    chk("w0_err", rsp_err, 1);
    chk("w0_rdata", rsp_rdata, 0);
    chk("w0_we", rf_we, 0);
    tick;
    chk("w0_idle", busy, 0);
    chk("w0_rsp_off", rsp_valid, 0);

    // port 0 read of addr 3 with DEPTH=3 is out of range
    req_valid = 2'b01; req_write = 2'b00; req_addr0 = 3;
    #1;
    chk("oor_ready", req_ready, 1);
    tick;
    req_valid = 2'b00;
    chk("oor_rsp", rsp_valid, 1);
    chk("oor_err", rsp_err, 1);
    chk("oor_re", rf_re, 0);
    tick;

    // reset while a write sits in ISSUE
    req_valid = 2'b10; req_write = 2'b10;
    req_addr1 = 2; req_wdata1 = 8'h5A;
    #1;
    tick;
    req_valid = 2'b00;
    chk("rw_issue_we", rf_we, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rw_we_cleared", rf_we, 0);
    chk("rw_busy_cleared", busy, 0);
    tick;
    rst = 1'b0;
    tick;
    chk("rw_we_after", rf_we, 0);
    chk("rw_rsp_after", rsp_valid, 0);
    chk("rw_busy_after", busy, 0);
    tick;
    chk("rw_we_after2", rf_we, 0);
    chk("rw_rsp_after2", rsp_valid, 0);
    req_valid = 2'b11; req_write = 2'b00;
    req_addr0 = 1; req_addr1 = 1;
    #1;
    chk("rw_cont_p0", req_ready, 1);
    req_valid = 2'b00;
    tick;
    chk("rw_no_acc", busy, 0);

`ifdef RF_ARB_PERF_EN
    chk("perf_rst0", grant_cnt0, 0);
    for (int k = 0; k < 3; k++) begin
      req_valid = 2'b01; req_write = 2'b00; req_addr0 = 3;
      #1;
      tick;
      req_valid = 2'b00;
      tick;
    end
    chk("perf_cnt0_3", grant_cnt0, 3);
    chk("perf_cnt1_0", grant_cnt1, 0);
    req_valid = 2'b01; clr_cnt = 1'b1;
    #1;
    tick;
    req_valid = 2'b00; clr_cnt = 1'b0;
    chk("perf_clr", grant_cnt0, 0);
    tick;
`endif

    // addr 2 must still hold its preload: the reset killed the write
    req_valid = 2'b01; req_write = 2'b00; req_addr0 = 2;
    #1;
    tick;
    req_valid = 2'b00;
    tick; tick;
    chk("rw_mem_rsp", rsp_valid, 1);
    chk("rw_mem_kept", rsp_rdata, 8'h22);
    tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
- Shares one register-file read/write port pair between two requesters (port 0, port 1).
- Round-robin arbitration, one transaction in flight at a time, valid/ready request handshake, single-cycle response pulse.
- Sits between the requesters and the register file. The register file has a registered read (1-cycle latency) and ignores writes to address 0.

Parameters:
DATA_W, 8, data width of register-file entries
ADDR_W, 2, address width
DEPTH, 4, number of implemented entries; legal addresses are 0..DEPTH-1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  2  per-port request valid
req_write  in  2  per-port op: 1 = write, 0 = read
req_addr0  in  ADDR_W  port 0 address
req_addr1  in  ADDR_W  port 1 address
req_wdata0  in  DATA_W  port 0 write data
req_wdata1  in  DATA_W  port 1 write data
req_ready  out  2  per-port accept; at most one bit high
rsp_valid  out  2  per-port response pulse, one cycle
rsp_err  out  1  error flag, qualified by rsp_valid
rsp_rdata  out  DATA_W  read data, qualified by rsp_valid on a read
rf_re  out  1  register-file read enable
rf_raddr  out  ADDR_W  register-file read address
rf_rdata  in  DATA_W  register-file read data, valid 1 cycle after rf_re
rf_we  out  1  register-file write enable
rf_waddr  out  ADDR_W  register-file write address
rf_wdata  out  DATA_W  register-file write data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state = IDLE; all outputs 0; rr_last = 1, so port 0 wins the first contention.
- Outputs: all registered except req_ready, which is combinational from state, req_valid and rr_last.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - Only one port valid: that port wins.
  - Both ports valid: the port != rr_last wins.
  - req_ready[winner] = 1 in IDLE only. Acceptance = valid && ready.
  - On acceptance, latch op, addr and wdata; rr_last <= winner; go to ISSUE.
- Legality check, done at acceptance:
  - Illegal if addr >= DEPTH.
  - Illegal if the op is a write to address 0.
  - An illegal op goes directly to RESP with err = 1. No rf_re or rf_we is asserted.
- ISSUE:
  - Write: rf_we = 1 for one cycle with rf_waddr/rf_wdata; next state RESP.
  - Read: rf_re = 1 for one cycle with rf_raddr; next state WAIT.
- WAIT: capture rf_rdata; next state RESP.
- RESP: rsp_valid[owner] = 1 for one cycle with rsp_err and rsp_rdata; next state IDLE.
  - rsp_rdata = 0 for writes and errors.
- Latency, acceptance at cycle A:
  - Legal write: rf_we at A+1, rsp at A+2.
  - Legal read: rf_re at A+1, data captured at A+2, rsp at A+3.
  - Error: rsp at A+1.
- Throughput: next acceptance no earlier than the rsp cycle + 1, because IDLE is re-entered after RESP.
- Rules for requesters:
  - Hold req_* stable while valid && !ready.
  - Requesters may drop valid without a penalty.
  - Responses are not backpressured.
- Reads of address 0 are legal and return whatever the register file drives.
- Reset mid-transaction: FSM returns to IDLE, the in-flight transaction is dropped with no response, and no rf_we pulse is emitted after reset deassertion.
- A request arriving during busy waits. A requester denied in a contention wins the next contention.

Optional Feature:
- Macro: RF_ARB_PERF_EN.
- Defined: adds grant_cnt0 and grant_cnt1 outputs, 16 bits each, and a clr_cnt input (1 bit, synchronous clear).
  - A counter increments on each acceptance for its port and saturates at 16'hFFFF.
  - Counters reset to 0 on rst.
  - clr_cnt has priority over an increment in the same cycle.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Port 0 writes addr 1 = 8'hA5, then reads addr 1 -> rf_we at A+1 with waddr 1 / wdata A5; write rsp err=0 at A+2; read rsp_rdata = 8'hA5 at (read acceptance)+3.
- Both ports valid at the same cycle, each making reads, held for 4 transactions -> grants alternate 0,1,0,1; req_ready never 2'b11.
- Port 1 writes addr 0 -> rsp_valid[1] at A+1 with rsp_err=1; rf_we stays 0.
- DEPTH=3, port 0 reads addr 3 -> rsp_err=1 at A+1; rf_re stays 0.
- Assert rst in the ISSUE cycle of a write -> rf_we never asserted afterward, no rsp_valid, busy=0; the next contention is granted to port 0.
- With RF_ARB_PERF_EN defined: 3 grants to port 0, then clr_cnt asserted together with a 4th grant -> grant_cnt0 = 3, then 0.
